// File: rtl/axi_burst_write_ctrl.sv
// -----------------------------------------------------------------------------
// axi_burst_write_ctrl
//   AXI4 master write-channel controller for the cache back-end. It captures one
//   request (a single word or a full line), then issues it as one AW/W burst
//   with both channels driven concurrently. A SLVERR/DECERR response replays
//   the identical burst, up to MAX_RETRY times. When the retries run out, the
//   completion is flagged with error.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   valid             request strobe; only sampled while idle
//   addr              byte address; low BYTE_W+BURST_W bits are dropped
//   wdata, wstrb      BEATS beats; beat k sits at [k*DATA_W +: DATA_W]
//   ready             one-cycle completion pulse
//   error             pulses with ready when every attempt failed
//   busy              a request is in flight
//   m_axi_aw*         AXI4 write-address channel (master side)
//   m_axi_w*          AXI4 write-data channel (master side)
//   m_axi_b*          AXI4 write-response channel (bid not used)
// -----------------------------------------------------------------------------
module axi_burst_write_ctrl #(
   parameter int              ADDR_W    = 32,
   parameter int              DATA_W    = 32,
   parameter int              BURST_W   = 2,
   parameter int              ID_W      = 1,
   parameter logic [ID_W-1:0] ID        = '0,
   parameter int              MAX_RETRY = 3
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              valid,
   input  logic [ADDR_W-1:0]                 addr,
   input  logic [DATA_W*(2**BURST_W)-1:0]    wdata,
   input  logic [(DATA_W/8)*(2**BURST_W)-1:0] wstrb,
   output logic                              ready,
   output logic                              error,
   output logic                              busy,
   output logic [ID_W-1:0]                   m_axi_awid,
   output logic [ADDR_W-1:0]                 m_axi_awaddr,
   output logic [7:0]                        m_axi_awlen,
   output logic [2:0]                        m_axi_awsize,
   output logic [1:0]                        m_axi_awburst,
   output logic                              m_axi_awlock,
   output logic [3:0]                        m_axi_awcache,
   output logic [2:0]                        m_axi_awprot,
   output logic                              m_axi_awvalid,
   input  logic                              m_axi_awready,
   output logic [DATA_W-1:0]                 m_axi_wdata,
   output logic [DATA_W/8-1:0]               m_axi_wstrb,
   output logic                              m_axi_wlast,
   output logic                              m_axi_wvalid,
   input  logic                              m_axi_wready,
   input  logic [1:0]                        m_axi_bresp,
   input  logic                              m_axi_bvalid,
   output logic                              m_axi_bready
);

   localparam int NBYTES  = DATA_W / 8;
   localparam int BYTE_W  = $clog2(NBYTES);
   localparam int BEATS   = 2 ** BURST_W;
   localparam int LOW_W   = BYTE_W + BURST_W;
   localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   // One extra bit so the beat counter can reach BEATS without wrapping.
   localparam int CNT_W   = BURST_W + 1;
   localparam int IDX_W   = (BURST_W > 0) ? BURST_W : 1;

   localparam logic [ADDR_W-1:0]  ALIGN_MASK = ~((ADDR_W'(1) << LOW_W) - ADDR_W'(1));
   localparam logic [CNT_W-1:0]   LAST_BEAT  = CNT_W'(BEATS - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

   typedef enum logic [1:0] {
      S_IDLE,
      S_XFER,
      S_RESP
   } state_t;

   state_t                     r_state;
   state_t                     w_next_state;
   logic [ADDR_W-1:0]          r_addr;
   logic [DATA_W*BEATS-1:0]    r_wdata;
   logic [NBYTES*BEATS-1:0]    r_wstrb;
   logic [CNT_W-1:0]           r_beat_cnt;
   logic [RETRY_W-1:0]         r_retry_cnt;
   logic                       r_aw_done;
   logic                       r_w_done;

   logic                       w_awvalid;
   logic                       w_wvalid;
   logic                       w_aw_hs;
   logic                       w_w_hs;
   logic                       w_last_beat;
   logic                       w_accept;
   logic                       w_retry;
   logic [IDX_W-1:0]           w_idx;
   logic                       w_unused_bresp0;

   // Only bresp[1] separates success from failure.
   assign w_unused_bresp0 = m_axi_bresp[0];

   // Constant burst attributes.
   assign m_axi_awid    = ID;
   assign m_axi_awaddr  = r_addr;
   assign m_axi_awlen   = 8'(BEATS - 1);
   assign m_axi_awsize  = 3'(BYTE_W);
   assign m_axi_awburst = (BURST_W == 0) ? 2'b00 : 2'b01;
   assign m_axi_awlock  = 1'b0;
   assign m_axi_awcache = 4'b0011;
   assign m_axi_awprot  = 3'b000;

   // AW and W run independently; each drops its valid once it has completed.
   assign w_awvalid     = (r_state == S_XFER) & ~r_aw_done;
   assign w_wvalid      = (r_state == S_XFER) & ~r_w_done;
   assign w_aw_hs       = w_awvalid & m_axi_awready;
   assign w_w_hs        = w_wvalid & m_axi_wready;
   assign w_last_beat   = (r_beat_cnt == LAST_BEAT);
   assign w_idx         = (BURST_W > 0) ? r_beat_cnt[IDX_W-1:0] : '0;

   assign m_axi_awvalid = w_awvalid;
   assign m_axi_wvalid  = w_wvalid;
   assign m_axi_wlast   = w_wvalid & w_last_beat;
   assign m_axi_wdata   = r_wdata[int'(w_idx) * DATA_W +: DATA_W];
   assign m_axi_wstrb   = r_wstrb[int'(w_idx) * NBYTES +: NBYTES];
   assign busy          = (r_state != S_IDLE);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // NOTE: every output of this block is given a default first, so no path
   // through the case statement can leave one unassigned and infer a latch.
   always_comb begin
      w_next_state = r_state;
      m_axi_bready = 1'b0;
      ready        = 1'b0;
      error        = 1'b0;
      w_accept     = 1'b0;
      w_retry      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (valid) begin
               w_accept     = 1'b1;
               w_next_state = S_XFER;
            end
         end
         S_XFER: begin
            // Leave as soon as both channels are done, counting a handshake
            // that completes in this very cycle.
            if ((r_aw_done | w_aw_hs) && (r_w_done | (w_w_hs & w_last_beat))) begin
               w_next_state = S_RESP;
            end
         end
         S_RESP: begin
            m_axi_bready = 1'b1;
            if (m_axi_bvalid) begin
               if (!m_axi_bresp[1]) begin
                  ready        = 1'b1;
                  w_next_state = S_IDLE;
               end else if (r_retry_cnt == RETRY_MAX) begin
                  ready        = 1'b1;
                  error        = 1'b1;
                  w_next_state = S_IDLE;
               end else begin
                  w_retry      = 1'b1;
                  w_next_state = S_XFER;
               end
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_beat_cnt  <= '0;
         r_retry_cnt <= '0;
         r_aw_done   <= 1'b0;
         r_w_done    <= 1'b0;
      end else if (w_accept || w_retry) begin
         // A new request and a replay both restart the burst from beat 0.
         r_beat_cnt  <= '0;
         r_aw_done   <= 1'b0;
         r_w_done    <= 1'b0;
         r_retry_cnt <= w_accept ? '0 : r_retry_cnt + RETRY_W'(1);
      end else begin
         if (w_aw_hs) begin
            r_aw_done <= 1'b1;
         end
         if (w_w_hs) begin
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            if (w_last_beat) begin
               r_w_done <= 1'b1;
            end
         end
      end
   end

   // NOTE: the request buffers carry no reset; they are always written before
   // being read, so a reset would only cost flops and routing.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_addr  <= addr & ALIGN_MASK;
         r_wdata <= wdata;
         r_wstrb <= wstrb;
      end
   end

endmodule

// File: tb/tb_axi_burst_write_ctrl.sv
// -----------------------------------------------------------------------------
// tb_axi_burst_write_ctrl
//   Main instance: 4-beat bursts, two retries. A transaction-level model
//   predicts every output on each cycle from the request and the slave's
//   handshakes. A second instance (single beat, no retries) is exercised with
//   hand-computed values only.
// -----------------------------------------------------------------------------
module tb_axi_burst_write_ctrl;

   localparam int BURST_W   = 2;
   localparam int BEATS     = 4;
   localparam int MAX_RETRY = 2;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   // ---------------- main instance ----------------
   logic         req_valid = 1'b0;
   logic [31:0]  req_addr  = '0;
   logic [127:0] req_wdata = '0;
   logic [15:0]  req_wstrb = '0;
   logic         dut_ready, dut_error, dut_busy;
   logic [0:0]   awid;
   logic [31:0]  awaddr;
   logic [7:0]   awlen;
   logic [2:0]   awsize;
   logic [1:0]   awburst;
   logic         awlock;
   logic [3:0]   awcache;
   logic [2:0]   awprot;
   logic         awvalid;
   logic         awready = 1'b0;
   logic [31:0]  wdata;
   logic [3:0]   wstrb;
   logic         wlast, wvalid;
   logic         wready = 1'b0;
   logic [1:0]   bresp  = 2'b00;
   logic         bvalid = 1'b0;
   logic         bready;

   axi_burst_write_ctrl #(
      .ADDR_W(32), .DATA_W(32), .BURST_W(BURST_W), .ID_W(1), .ID(1'b0), .MAX_RETRY(MAX_RETRY)
   ) u_dut (
      .clk(clk), .reset(reset), .valid(req_valid), .addr(req_addr),
      .wdata(req_wdata), .wstrb(req_wstrb),
      .ready(dut_ready), .error(dut_error), .busy(dut_busy),
      .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
      .m_axi_awsize(awsize), .m_axi_awburst(awburst), .m_axi_awlock(awlock),
      .m_axi_awcache(awcache), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
      .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
      .m_axi_wlast(wlast), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
      .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready)
   );

   // ---------------- single-beat instance ----------------
   logic        d1_valid = 1'b0;
   logic [31:0] d1_addr  = '0;
   logic [31:0] d1_wdata = '0;
   logic [3:0]  d1_wstrb = '0;
   logic        d1_ready, d1_error, d1_busy;
   logic [0:0]  d1_awid;
   logic [31:0] d1_awaddr;
   logic [7:0]  d1_awlen;
   logic [2:0]  d1_awsize;
   logic [1:0]  d1_awburst;
   logic        d1_awlock;
   logic [3:0]  d1_awcache;
   logic [2:0]  d1_awprot;
   logic        d1_awvalid;
   logic        d1_awready = 1'b1;
   logic [31:0] d1_wdata_o;
   logic [3:0]  d1_wstrb_o;
   logic        d1_wlast, d1_wvalid;
   logic        d1_wready = 1'b1;
   logic [1:0]  d1_bresp  = 2'b00;
   logic        d1_bvalid;
   logic        d1_bready;

   // The response arrives in the same cycle bready rises.
   assign d1_bvalid = d1_bready;

   axi_burst_write_ctrl #(
      .ADDR_W(32), .DATA_W(32), .BURST_W(0), .ID_W(1), .ID(1'b0), .MAX_RETRY(0)
   ) u_dut1 (
      .clk(clk), .reset(reset), .valid(d1_valid), .addr(d1_addr),
      .wdata(d1_wdata), .wstrb(d1_wstrb),
      .ready(d1_ready), .error(d1_error), .busy(d1_busy),
      .m_axi_awid(d1_awid), .m_axi_awaddr(d1_awaddr), .m_axi_awlen(d1_awlen),
      .m_axi_awsize(d1_awsize), .m_axi_awburst(d1_awburst), .m_axi_awlock(d1_awlock),
      .m_axi_awcache(d1_awcache), .m_axi_awprot(d1_awprot), .m_axi_awvalid(d1_awvalid),
      .m_axi_awready(d1_awready), .m_axi_wdata(d1_wdata_o), .m_axi_wstrb(d1_wstrb_o),
      .m_axi_wlast(d1_wlast), .m_axi_wvalid(d1_wvalid), .m_axi_wready(d1_wready),
      .m_axi_bresp(d1_bresp), .m_axi_bvalid(d1_bvalid), .m_axi_bready(d1_bready)
   );

   // ---------------- checking ----------------
   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   // Progress of the current request: whether its address has been sent, how
   // many beats have been sent and which attempt this is.
   logic        m_busy    = 1'b0;
   logic        m_aw_sent = 1'b0;
   int          m_beats   = 0;
   int          m_tries   = 0;
   logic [31:0] m_addr    = '0;
   logic [31:0] m_data [BEATS];
   logic [3:0]  m_strb [BEATS];

   logic p_xfer, p_awvalid, p_wvalid, p_wlast, p_bready, p_final, p_ready, p_error;

   always_comb begin
      p_xfer    = m_busy && !(m_aw_sent && m_beats == BEATS);
      p_awvalid = p_xfer && !m_aw_sent;
      p_wvalid  = p_xfer && (m_beats < BEATS);
      p_wlast   = p_wvalid && (m_beats == BEATS - 1);
      p_bready  = m_busy && m_aw_sent && (m_beats == BEATS);
      p_final   = !bresp[1] || (m_tries == MAX_RETRY + 1);
      p_ready   = p_bready && bvalid && p_final;
      p_error   = p_ready && bresp[1];
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_busy    <= 1'b0;
         m_aw_sent <= 1'b0;
         m_beats   <= 0;
         m_tries   <= 0;
      end else if (!m_busy) begin
         if (req_valid) begin
            m_busy    <= 1'b1;
            m_aw_sent <= 1'b0;
            m_beats   <= 0;
            m_tries   <= 1;
            m_addr    <= {req_addr[31:4], 4'h0};
            for (int k = 0; k < BEATS; k++) begin
               m_data[k] <= req_wdata[k*32 +: 32];
               m_strb[k] <= req_wstrb[k*4 +: 4];
            end
         end
      end else if (p_bready) begin
         if (bvalid) begin
            if (p_final) begin
               m_busy <= 1'b0;
            end else begin
               m_tries   <= m_tries + 1;
               m_aw_sent <= 1'b0;
               m_beats   <= 0;
            end
         end
      end else begin
         if (p_awvalid && awready) m_aw_sent <= 1'b1;
         if (p_wvalid && wready)   m_beats   <= m_beats + 1;
      end
   end

   // Compare every cycle, away from the active edge.
   always @(negedge clk) begin
      check("ctrl", {awvalid, wvalid, wlast, bready, dut_ready, dut_error, dut_busy},
                    {p_awvalid, p_wvalid, p_wlast, p_bready, p_ready, p_error, m_busy});
      if (p_awvalid)
         check("aw", {awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot},
                     {1'b0, m_addr, 8'd3, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000});
      if (p_wvalid)
         check("w", {wdata, wstrb}, {m_data[m_beats], m_strb[m_beats]});
   end

   // ---------------- event monitor ----------------
   int   cyc = 0, n_aw_hs = 0, n_w_hs = 0, n_wlast_hs = 0, n_ready = 0, n_error = 0;
   int   last_aw_cyc = 0, bready_rise_cyc = 0;
   logic prev_bready = 1'b0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (awvalid && awready) begin
         n_aw_hs     <= n_aw_hs + 1;
         last_aw_cyc <= cyc;
      end
      if (wvalid && wready) begin
         n_w_hs <= n_w_hs + 1;
         if (wlast) n_wlast_hs <= n_wlast_hs + 1;
      end
      if (dut_ready) n_ready <= n_ready + 1;
      if (dut_error) n_error <= n_error + 1;
      if (bready && !prev_bready) bready_rise_cyc <= cyc;
      prev_bready <= bready;
   end

   // ---------------- slave model ----------------
   int         aw_delay = 0;
   bit         aw_rand  = 1'b0;
   int         w_mode   = 0;     // 0 always ready, 1 toggling, 2 random
   bit         b_rand   = 1'b0;
   logic [1:0] bresp_q[$];
   int         b_idx    = 0;
   int         aw_wait  = 0;
   bit         w_tog    = 1'b0;

   always @(posedge clk) begin
      if (reset)                    aw_wait = 0;
      else if (awvalid && awready)  aw_wait = 0;
      else if (awvalid)             aw_wait++;
      if (!reset && bvalid && bready) b_idx++;
      w_tog = !w_tog;
      #1;
      awready = aw_rand ? 1'($urandom_range(0, 1)) : (aw_wait >= aw_delay);
      case (w_mode)
         0:       wready = 1'b1;
         1:       wready = w_tog;
         default: wready = 1'($urandom_range(0, 1));
      endcase
      bvalid = bready && (b_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
      bresp  = (b_idx < bresp_q.size()) ? bresp_q[b_idx] : 2'b00;
   end

   // ---------------- stimulus ----------------
   int s_aw, s_w, s_wl, s_rdy, s_err;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic snap();
      s_aw = n_aw_hs; s_w = n_w_hs; s_wl = n_wlast_hs; s_rdy = n_ready; s_err = n_error;
   endtask

   task automatic start_req(input logic [31:0] a, input logic [127:0] d, input logic [15:0] s);
      req_valid = 1'b1;
      req_addr  = a;
      req_wdata = d;
      req_wstrb = s;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n = 0;
      while (dut_busy && n < budget) begin
         tick();
         n++;
      end
      check({name, "_idle"}, dut_busy, 1'b0);
   endtask

   initial begin
      repeat (3) tick();
      check("rst_main", {dut_busy, awvalid, wvalid, bready, dut_ready, dut_error}, 6'b0);
      check("rst_d1", {d1_busy, d1_awvalid, d1_wvalid, d1_bready, d1_ready, d1_error}, 6'b0);
      reset = 1'b0;
      tick();

      // T1: single beat, OKAY response.
      d1_valid = 1'b1; d1_addr = 32'h1007; d1_wdata = 32'hDEADBEEF; d1_wstrb = 4'hF; d1_bresp = 2'b00;
      tick();
      d1_valid = 1'b0;
      check("t1_aw", {d1_awvalid, d1_awaddr, d1_awlen, d1_awsize, d1_awburst},
                     {1'b1, 32'h1004, 8'd0, 3'd2, 2'b00});
      check("t1_w", {d1_wvalid, d1_wlast, d1_wdata_o, d1_wstrb_o, d1_ready},
                    {1'b1, 1'b1, 32'hDEADBEEF, 4'hF, 1'b0});
      tick();
      check("t1_cycle2", {d1_bready, d1_ready, d1_error, d1_awvalid, d1_wvalid}, 5'b11000);
      tick();
      check("t1_cycle3", {d1_busy, d1_ready}, 2'b00);
      // No retries allowed: the first failure ends the request with error.
      d1_valid = 1'b1; d1_addr = 32'h0000_2468; d1_bresp = 2'b10;
      tick();
      d1_valid = 1'b0;
      tick();
      check("t1_err", {d1_bready, d1_ready, d1_error}, 3'b111);
      tick();
      check("t1_err_after", {d1_busy, d1_ready, d1_error}, 3'b000);

      // T2: delayed awready, toggling wready.
      aw_delay = 5; w_mode = 1; bresp_q.push_back(2'b00); snap();
      start_req(32'h203C, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 16'hFFFF);
      check("t2_aw", {awvalid, awaddr, awlen, awburst, awsize}, {1'b1, 32'h2030, 8'd3, 2'b01, 3'd2});
      check("t2_beat0", {wvalid, wdata}, {1'b1, 32'h11111111});
      wait_idle(60, "t2");
      check("t2_counts", {n_w_hs - s_w, n_wlast_hs - s_wl, n_ready - s_rdy}, {32'd4, 32'd1, 32'd1});

      // T3: AW held off for 10 cycles while W completes.
      aw_delay = 10; w_mode = 0; bresp_q.push_back(2'b00);
      start_req(32'h0000_0100, {4{32'hA5A5_0F0F}}, 16'h0F3C);
      repeat (4) tick();
      check("t3_w_done_aw_held", {wvalid, awvalid}, 2'b01);
      wait_idle(60, "t3");
      check("t3_resp_lat", bready_rise_cyc - last_aw_cyc, 1);

      // T4: two failures then OKAY.
      aw_delay = 0; w_mode = 0;
      bresp_q.push_back(2'b10); bresp_q.push_back(2'b10); bresp_q.push_back(2'b00); snap();
      start_req(32'h0000_4440, {32'h4, 32'h3, 32'h2, 32'h1}, 16'hF0F0);
      wait_idle(100, "t4");
      check("t4_bursts", n_aw_hs - s_aw, 3);
      check("t4_ready_err", {n_ready - s_rdy, n_error - s_err}, {32'd1, 32'd0});

      // T5: every attempt fails.
      bresp_q.push_back(2'b11); bresp_q.push_back(2'b11); bresp_q.push_back(2'b11); snap();
      start_req(32'h0000_5550, {32'h55, 32'h66, 32'h77, 32'h88}, 16'hFFFF);
      for (int n = 0; n < 100 && !dut_ready; n++) tick();
      check("t5_pulse", {dut_ready, dut_error}, 2'b11);
      tick();
      check("t5_after", {dut_busy, dut_ready, dut_error}, 3'b000);
      check("t5_bursts", n_aw_hs - s_aw, 3);

      // T6: reset after beat 1 of 4.
      aw_delay = 20;
      start_req(32'h0000_6000, {32'hD, 32'hC, 32'hB, 32'hA}, 16'hFFFF);
      tick(); tick();
      reset = 1'b1;
      #1;
      check("t6_reset", {awvalid, wvalid, dut_busy}, 3'b000);
      tick(); tick();
      reset = 1'b0;
      tick();
      aw_delay = 0; snap();
      bresp_q.push_back(2'b10); bresp_q.push_back(2'b10); bresp_q.push_back(2'b00);
      start_req(32'h0000_7008, {32'h7777_0003, 32'h7777_0002, 32'h7777_0001, 32'h7777_0000}, 16'h1234);
      check("t6_restart", {wvalid, wdata, wstrb}, {1'b1, 32'h7777_0000, 4'h4});
      wait_idle(100, "t6");
      check("t6_full_retry", {n_aw_hs - s_aw, n_error - s_err}, {32'd3, 32'd0});

      // T7: a second valid while busy is ignored.
      aw_delay = 4; bresp_q.push_back(2'b00);
      start_req(32'h0000_4010, {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000}, 16'hFFFF);
      req_valid = 1'b1; req_addr = 32'h0000_5550; req_wdata = '1; req_wstrb = 16'h0;
      tick();
      req_valid = 1'b0;
      check("t7_addr", {awvalid, awaddr}, {1'b1, 32'h4010});
      wait_idle(60, "t7");

      // Randomised traffic with spurious valids while busy.
      aw_rand = 1'b1; w_mode = 2; b_rand = 1'b1;
      for (int t = 0; t < 30; t++) begin
         int nf;
         int n;
         nf = $urandom_range(0, 3);
         for (int j = 0; j < nf && j <= MAX_RETRY; j++) bresp_q.push_back({1'b1, 1'($urandom_range(0, 1))});
         if (nf <= MAX_RETRY) bresp_q.push_back({1'b0, 1'($urandom_range(0, 1))});
         start_req($urandom, {$urandom, $urandom, $urandom, $urandom}, 16'($urandom));
         n = 0;
         while (dut_busy && n < 300) begin
            req_valid = ($urandom_range(0, 5) == 0);
            req_addr  = $urandom;
            req_wdata = {$urandom, $urandom, $urandom, $urandom};
            tick();
            n++;
         end
         req_valid = 1'b0;
         check("rand_idle", dut_busy, 1'b0);
      end

      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (checks=%0d failures=%0d)", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
